// File: rtl/adapter_axi_stream_2_ppfifo.sv
// AXI Stream slave to Ping Pong FIFO write-side adapter; tuser[0] rides in the PPFIFO word MSB.
// Optional: define ADAPTER_AXI_2_PPFIFO_TLAST_RELEASE_EN to also release the half on tlast.
module adapter_axi_stream_2_ppfifo #(
    parameter int DATA_WIDTH   = 24,
    parameter int STROBE_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_axi_clk,
    input  logic                  rst_n,
    input  logic [3:0]            i_axi_user,
    input  logic [DATA_WIDTH-1:0] i_axi_data,
    input  logic                  i_axi_last,
    input  logic                  i_axi_valid,
    output logic                  o_axi_ready,
    input  logic [1:0]            i_ppfifo_rdy,
    output logic [1:0]            o_ppfifo_act,
    input  logic [23:0]           i_ppfifo_size,
    output logic                  o_ppfifo_stb,
    output logic [DATA_WIDTH:0]   o_ppfifo_data,
    output logic [31:0]           o_debug
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        READY   = 4'd1,
        RELEASE = 4'd2
    } state_t;

    state_t      state;
    logic [23:0] r_count;
    logic [24:0] count_next;
    logic        beat;
    logic        release_hit;
    logic        unused_inputs;

    // 25-bit increment so a half of 2^24-1 words never wraps the compare
    assign count_next = {1'b0, r_count} + 25'd1;
    assign beat       = i_axi_valid & o_axi_ready;

`ifdef ADAPTER_AXI_2_PPFIFO_TLAST_RELEASE_EN
    assign release_hit   = (count_next >= {1'b0, i_ppfifo_size}) | i_axi_last;
    assign unused_inputs = ^{i_axi_user[3:1], (STROBE_WIDTH > 0)};
`else
    assign release_hit   = (count_next >= {1'b0, i_ppfifo_size});
    assign unused_inputs = ^{i_axi_user[3:1], i_axi_last, (STROBE_WIDTH > 0)};
`endif

    assign o_axi_ready = (state == READY) && (o_ppfifo_act != 2'b00) &&
                         (r_count < i_ppfifo_size);

    assign o_debug = {r_count[15:0], 6'd0, i_axi_valid, o_axi_ready,
                      i_ppfifo_rdy, o_ppfifo_act, state};

    always_ff @(posedge i_axi_clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            o_ppfifo_act  <= 2'b00;
            r_count       <= 24'd0;
            o_ppfifo_stb  <= 1'b0;
            o_ppfifo_data <= '0;
        end else begin
            o_ppfifo_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if ((o_ppfifo_act == 2'b00) && (i_ppfifo_rdy != 2'b00)) begin
                        r_count      <= 24'd0;
                        o_ppfifo_act <= i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
                        state        <= READY;
                    end
                end
                READY: begin
                    if (i_ppfifo_size == 24'd0) begin
                        o_ppfifo_act <= 2'b00;
                        state        <= RELEASE;
                    end else if (beat) begin
                        o_ppfifo_stb  <= 1'b1;
                        o_ppfifo_data <= {i_axi_user[0], i_axi_data};
                        r_count       <= count_next[23:0];
                        // the last strobe of a half lands in the same cycle act falls
                        if (release_hit) begin
                            o_ppfifo_act <= 2'b00;
                            state        <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    o_ppfifo_act <= 2'b00;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adapter_axi_stream_2_ppfifo.sv
// Bench for adapter_axi_stream_2_ppfifo: PPFIFO write-side model plus per-half word/segment scoreboard.
module tb_adapter_axi_stream_2_ppfifo;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    i_axi_user = 4'd0;
    logic [DW-1:0] i_axi_data = '0;
    logic          i_axi_last = 1'b0;
    logic          i_axi_valid = 1'b0;
    logic          o_axi_ready;
    logic [1:0]    i_ppfifo_rdy = 2'b11;
    logic [1:0]    o_ppfifo_act;
    logic [23:0]   i_ppfifo_size = 24'd4;
    logic          o_ppfifo_stb;
    logic [DW:0]   o_ppfifo_data;
    logic [31:0]   o_debug;

    adapter_axi_stream_2_ppfifo #(.DATA_WIDTH(DW)) dut (
        .i_axi_clk     (clk),
        .rst_n         (rst_n),
        .i_axi_user    (i_axi_user),
        .i_axi_data    (i_axi_data),
        .i_axi_last    (i_axi_last),
        .i_axi_valid   (i_axi_valid),
        .o_axi_ready   (o_axi_ready),
        .i_ppfifo_rdy  (i_ppfifo_rdy),
        .o_ppfifo_act  (o_ppfifo_act),
        .i_ppfifo_size (i_ppfifo_size),
        .o_ppfifo_stb  (o_ppfifo_stb),
        .o_ppfifo_data (o_ppfifo_data),
        .o_debug       (o_debug)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // PPFIFO model state: a half is busy from activation until drain cycles after release
    logic [1:0] avail = 2'b11;
    logic [1:0] busy = 2'b00;
    int         dcnt[2];
    int         drain = 1000;

    logic [1:0]    prev_act = 2'b00;
    int            seg = 0;
    int            zero_run = 0;
    logic [DW:0]   obs_word[$];
    int            obs_seg[$];
    logic [1:0]    obs_act[$];
    logic [1:0]    half_q[$];
    int            gap_q[$];
    logic [DW-1:0] bq_data[$];
    logic          bq_user[$];
    logic          bq_last[$];
    int            stb_mismatch = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        for (int h = 0; h < 2; h++) begin
            if (!rst_n) begin
                busy[h] = 1'b0;
                dcnt[h] = 0;
            end else if (o_ppfifo_act[h]) begin
                busy[h] = 1'b1;
                dcnt[h] = drain;
            end else if (busy[h]) begin
                if (dcnt[h] == 0) busy[h] = 1'b0;
                else dcnt[h]--;
            end
        end
        i_ppfifo_rdy = avail & ~busy;
        if (o_ppfifo_act != 2'b00 && prev_act == 2'b00) begin
            if (seg > 0) gap_q.push_back(zero_run);
            seg++;
            half_q.push_back(o_ppfifo_act);
        end
        zero_run = (o_ppfifo_act == 2'b00) ? zero_run + 1 : 0;
        if (o_ppfifo_stb) begin
            obs_word.push_back(o_ppfifo_data);
            obs_seg.push_back(seg);
            obs_act.push_back(o_ppfifo_act);
        end
        prev_act = o_ppfifo_act;
    endtask

    task automatic clear_records();
        obs_word.delete();
        obs_seg.delete();
        obs_act.delete();
        half_q.delete();
        gap_q.delete();
        seg = 0;
        zero_run = 0;
        prev_act = 2'b00;
    endtask

    task automatic reset_dut(input int n, input logic [23:0] sz, input logic [1:0] av, input int dr);
        rst_n = 1'b0;
        i_axi_valid = 1'b0;
        i_axi_last = 1'b0;
        tick();
        i_ppfifo_size = sz;
        avail = av;
        drain = dr;
        repeat (n - 1) tick();
        rst_n = 1'b1;
        clear_records();
    endtask

    task automatic add_beat(input logic [DW-1:0] d, input logic u, input logic l);
        bq_data.push_back(d);
        bq_user.push_back(u);
        bq_last.push_back(l);
    endtask

    // mode 0: continuous valid, 1: alternate valid, 2: random valid
    task automatic stream(input int mode, input int budget);
        int   idx = 0;
        int   cyc = 0;
        logic tog = 1'b1;
        logic r;
        logic hs;
        stb_mismatch = 0;
        while (idx < bq_data.size()) begin
            if (!i_axi_valid) begin
                case (mode)
                    0: i_axi_valid = 1'b1;
                    1: begin i_axi_valid = tog; tog = ~tog; end
                    default: i_axi_valid = 1'($urandom_range(0, 1));
                endcase
                i_axi_data = bq_data[idx];
                i_axi_user = {3'($urandom_range(0, 7)), bq_user[idx]};
                i_axi_last = bq_last[idx];
            end
            r = o_axi_ready;
            hs = i_axi_valid && r;
            tick();
            if (o_ppfifo_stb !== hs) stb_mismatch++;
            if (hs) begin
                idx++;
                i_axi_valid = 1'b0;
                i_axi_last = 1'b0;
            end
            cyc++;
            if (cyc > budget) begin
                checks++; errors++;
                $display("FAIL stream_timeout got %0d beats want %0d", idx, bq_data.size());
                i_axi_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_axi_valid = 1'b0;
        avail = 2'b11;
        drain = 1000;
        i_ppfifo_size = 24'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_ppfifo_act !== 2'b00) begin errors++; $display("FAIL reset_act got %b want 00", o_ppfifo_act); end
            checks++; if (o_axi_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_axi_ready); end
            checks++; if (o_ppfifo_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", o_ppfifo_stb); end
        end
        checks++; if (o_ppfifo_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", o_ppfifo_data); end
        rst_n = 1'b1;
        clear_records();
        tick();
        checks++; if (o_ppfifo_act !== 2'b01) begin errors++; $display("FAIL reset_first_act got %b want 01", o_ppfifo_act); end
        checks++; if (o_debug[5:4] !== 2'b01) begin errors++; $display("FAIL reset_debug_act got %b want 01", o_debug[5:4]); end
        checks++; if (o_axi_ready !== 1'b1) begin errors++; $display("FAIL reset_first_ready got %b want 1", o_axi_ready); end
    endtask

    task automatic test_full_fill();
        reset_dut(2, 24'd4, 2'b01, 1000);
        bq_data.delete(); bq_user.delete(); bq_last.delete();
        for (int i = 1; i <= 4; i++) add_beat(DW'(i), (i == 1), 1'b0);
        stream(0, 100);
        checks++; if (obs_word.size() !== 4) begin errors++; $display("FAIL fill_count got %0d want 4", obs_word.size()); end
        for (int i = 0; i < obs_word.size() && i < 4; i++) begin
            logic [DW:0] e;
            logic [1:0]  ea;
            e = {(i == 0), DW'(i + 1)};
            ea = (i == 3) ? 2'b00 : 2'b01;
            checks++; if (obs_word[i] !== e) begin errors++; $display("FAIL fill_word%0d got %h want %h", i, obs_word[i], e); end
            checks++; if (obs_act[i] !== ea) begin errors++; $display("FAIL fill_act_at_stb%0d got %b want %b", i, obs_act[i], ea); end
        end
        checks++; if (stb_mismatch !== 0) begin errors++; $display("FAIL fill_stb_vs_handshake got %0d want 0", stb_mismatch); end
        checks++; if (o_axi_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_rel got %b want 0", o_axi_ready); end
        checks++; if (o_debug[31:16] !== 16'd4) begin errors++; $display("FAIL fill_rcount got %0d want 4", o_debug[31:16]); end
        tick();
        checks++; if (o_axi_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_gap got %b want 0", o_axi_ready); end
        checks++; if (o_ppfifo_stb !== 1'b0) begin errors++; $display("FAIL fill_stb_after got %b want 0", o_ppfifo_stb); end
    endtask

    task automatic test_ping_pong();
        reset_dut(2, 24'd2, 2'b11, 4);
        bq_data.delete(); bq_user.delete(); bq_last.delete();
        for (int i = 0; i < 6; i++) add_beat(DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        stream(0, 200);
        checks++; if (half_q.size() !== 3) begin errors++; $display("FAIL pp_halves got %0d want 3", half_q.size()); end
        for (int i = 0; i < half_q.size() && i < 3; i++) begin
            logic [1:0] eh;
            eh = (i == 1) ? 2'b10 : 2'b01;
            checks++; if (half_q[i] !== eh) begin errors++; $display("FAIL pp_half%0d got %b want %b", i, half_q[i], eh); end
        end
        for (int i = 0; i < gap_q.size(); i++) begin
            checks++; if (gap_q[i] !== 2) begin errors++; $display("FAIL pp_gap%0d got %0d want 2", i, gap_q[i]); end
        end
        checks++; if (obs_word.size() !== 6) begin errors++; $display("FAIL pp_words got %0d want 6", obs_word.size()); end
        for (int i = 0; i < obs_word.size() && i < 6; i++) begin
            checks++; if (obs_word[i] !== {bq_user[i], bq_data[i]}) begin errors++; $display("FAIL pp_word%0d got %h want %h", i, obs_word[i], {bq_user[i], bq_data[i]}); end
            checks++; if (obs_seg[i] !== i / 2 + 1) begin errors++; $display("FAIL pp_seg%0d got %0d want %0d", i, obs_seg[i], i / 2 + 1); end
        end
    endtask

    task automatic test_backpressure();
        reset_dut(2, 24'd3, 2'b01, 1000);
        bq_data.delete(); bq_user.delete(); bq_last.delete();
        for (int i = 0; i < 3; i++) add_beat(DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        stream(1, 100);
        checks++; if (stb_mismatch !== 0) begin errors++; $display("FAIL bp_stb_vs_handshake got %0d want 0", stb_mismatch); end
        checks++; if (obs_word.size() !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", obs_word.size()); end
        for (int i = 0; i < obs_word.size() && i < 3; i++) begin
            checks++; if (obs_word[i] !== {bq_user[i], bq_data[i]}) begin errors++; $display("FAIL bp_word%0d got %h want %h", i, obs_word[i], {bq_user[i], bq_data[i]}); end
        end
        checks++; if (o_debug[31:16] !== 16'd3) begin errors++; $display("FAIL bp_rcount got %0d want 3", o_debug[31:16]); end
        checks++; if (o_ppfifo_act !== 2'b00) begin errors++; $display("FAIL bp_act_rel got %b want 00", o_ppfifo_act); end
    endtask

    task automatic test_zero_size();
        int pulses = 0;
        int run = 0;
        int max_run = 0;
        int rdy_hits = 0;
        int stb_hits = 0;
        reset_dut(2, 24'd0, 2'b01, 2);
        i_axi_valid = 1'b1;
        i_axi_data = DW'($urandom);
        tick();
        checks++; if (o_ppfifo_act !== 2'b01) begin errors++; $display("FAIL zero_act_on got %b want 01", o_ppfifo_act); end
        checks++; if (o_axi_ready !== 1'b0) begin errors++; $display("FAIL zero_ready got %b want 0", o_axi_ready); end
        tick();
        checks++; if (o_ppfifo_act !== 2'b00) begin errors++; $display("FAIL zero_act_off got %b want 00", o_ppfifo_act); end
        for (int i = 0; i < 14; i++) begin
            tick();
            if (o_ppfifo_act != 2'b00) begin
                if (run == 0) pulses++;
                run++;
                if (run > max_run) max_run = run;
            end else run = 0;
            if (o_axi_ready) rdy_hits++;
            if (o_ppfifo_stb) stb_hits++;
        end
        i_axi_valid = 1'b0;
        checks++; if (pulses < 2) begin errors++; $display("FAIL zero_reactivate got %0d want >=2", pulses); end
        checks++; if (max_run !== 1) begin errors++; $display("FAIL zero_pulse_width got %0d want 1", max_run); end
        checks++; if (rdy_hits !== 0) begin errors++; $display("FAIL zero_ready_cycles got %0d want 0", rdy_hits); end
        checks++; if (stb_hits !== 0) begin errors++; $display("FAIL zero_stb_cycles got %0d want 0", stb_hits); end
    endtask

    task automatic test_tlast();
        reset_dut(2, 24'd8, 2'b01, 1000);
        bq_data.delete(); bq_user.delete(); bq_last.delete();
        for (int i = 0; i < 3; i++) add_beat(DW'($urandom), 1'($urandom_range(0, 1)), (i == 2));
        stream(0, 100);
        checks++; if (obs_word.size() !== 3) begin errors++; $display("FAIL tlast_count got %0d want 3", obs_word.size()); end
        for (int i = 0; i < obs_word.size() && i < 3; i++) begin
            checks++; if (obs_word[i] !== {bq_user[i], bq_data[i]}) begin errors++; $display("FAIL tlast_word%0d got %h want %h", i, obs_word[i], {bq_user[i], bq_data[i]}); end
        end
`ifdef ADAPTER_AXI_2_PPFIFO_TLAST_RELEASE_EN
        checks++; if (o_ppfifo_act !== 2'b00) begin errors++; $display("FAIL tlast_act got %b want 00", o_ppfifo_act); end
        checks++; if (o_axi_ready !== 1'b0) begin errors++; $display("FAIL tlast_ready got %b want 0", o_axi_ready); end
`else
        checks++; if (o_ppfifo_act !== 2'b01) begin errors++; $display("FAIL tlast_act got %b want 01", o_ppfifo_act); end
        checks++; if (o_axi_ready !== 1'b1) begin errors++; $display("FAIL tlast_ready got %b want 1", o_axi_ready); end
`endif
    endtask

    task automatic test_midfill_reset();
        reset_dut(2, 24'd8, 2'b01, 1000);
        bq_data.delete(); bq_user.delete(); bq_last.delete();
        for (int i = 0; i < 2; i++) add_beat(DW'($urandom), 1'b0, 1'b0);
        stream(0, 100);
        rst_n = 1'b0;
        tick();
        checks++; if (o_ppfifo_act !== 2'b00) begin errors++; $display("FAIL mid_act got %b want 00", o_ppfifo_act); end
        checks++; if (o_ppfifo_stb !== 1'b0) begin errors++; $display("FAIL mid_stb got %b want 0", o_ppfifo_stb); end
        checks++; if (o_debug[31:16] !== 16'd0) begin errors++; $display("FAIL mid_rcount got %0d want 0", o_debug[31:16]); end
        rst_n = 1'b1;
        clear_records();
        tick();
        checks++; if (o_ppfifo_act !== 2'b01) begin errors++; $display("FAIL mid_reacquire got %b want 01", o_ppfifo_act); end
        checks++; if (o_axi_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", o_axi_ready); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int sz;
            int n;
            int cnt;
            int exp_segs[$];
            int got_segs[$];
            int maxs;
            sz = $urandom_range(1, 5);
            n = 20;
            reset_dut(2, 24'(sz), 2'b11, $urandom_range(2, 6));
            bq_data.delete(); bq_user.delete(); bq_last.delete();
            for (int i = 0; i < n; i++)
                add_beat(DW'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            // reference: each half holds size words (or ends early at tlast when enabled)
            cnt = 0;
            for (int i = 0; i < n; i++) begin
                logic fin;
                cnt++;
                fin = (cnt == sz);
`ifdef ADAPTER_AXI_2_PPFIFO_TLAST_RELEASE_EN
                fin = fin | bq_last[i];
`endif
                if (fin) begin exp_segs.push_back(cnt); cnt = 0; end
            end
            if (cnt > 0) exp_segs.push_back(cnt);
            stream(2, 3000);
            maxs = (obs_seg.size() > 0) ? obs_seg[obs_seg.size() - 1] : 0;
            for (int s = 0; s < maxs; s++) got_segs.push_back(0);
            foreach (obs_seg[i]) got_segs[obs_seg[i] - 1]++;
            checks++; if (stb_mismatch !== 0) begin errors++; $display("FAIL rnd%0d_stb_vs_handshake got %0d want 0", it, stb_mismatch); end
            checks++; if (obs_word.size() !== n) begin errors++; $display("FAIL rnd%0d_words got %0d want %0d", it, obs_word.size(), n); end
            for (int i = 0; i < obs_word.size() && i < n; i++) begin
                checks++; if (obs_word[i] !== {bq_user[i], bq_data[i]}) begin errors++; $display("FAIL rnd%0d_word%0d got %h want %h", it, i, obs_word[i], {bq_user[i], bq_data[i]}); end
            end
            checks++; if (got_segs.size() !== exp_segs.size()) begin errors++; $display("FAIL rnd%0d_halves got %0d want %0d", it, got_segs.size(), exp_segs.size()); end
            for (int i = 0; i < got_segs.size() && i < exp_segs.size(); i++) begin
                checks++; if (got_segs[i] !== exp_segs[i]) begin errors++; $display("FAIL rnd%0d_half%0d_words got %0d want %0d", it, i, got_segs[i], exp_segs[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_fill();
        test_ping_pong();
        test_backpressure();
        test_zero_size();
        test_tlast();
        test_midfill_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
